fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of `control`. It owns the program counter and drives `instr_addr` / `data_addr` into `flash_instr` / `flash_data`. It captures the returned instruction and data words, with their PC, into a small in-order buffer and presents them to `control` over a valid/ready handshake. It also handles branch redirects from `control` and a halt request.

---
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads both flashes at the fetch PC and
// queues {instr, data, pc} for control. FETCH_SKID2_EN selects a 2-entry skid buffer.
module fetch_unit #(
  parameter int                 ADDR_W   = 8,
  parameter int                 WORD_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [WORD_W-1:0] instr_in,
  output logic [ADDR_W-1:0] data_addr,
  input  logic [WORD_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_instr,
  output logic [WORD_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              wrapped
);

`ifdef FETCH_SKID2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] data;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  entry_t            fifo_q    [DEPTH];
  entry_t            shift_src [DEPTH];
  entry_t            new_entry;
  logic [1:0]        cnt;
  logic [1:0]        wr_idx;
  logic [ADDR_W-1:0] fpc;
  logic              wrapped_q;
  logic              pop;
  logic              can_push;
  logic              push;

  assign instr_addr = fpc;
  assign data_addr  = fpc;
  assign out_valid  = (cnt != 2'd0);
  assign out_instr  = fifo_q[0].instr;
  assign out_data   = fifo_q[0].data;
  assign out_pc     = fifo_q[0].pc;
  assign wrapped    = wrapped_q;
  assign new_entry  = '{instr: instr_in, data: data_in, pc: fpc};

  // Skid build decouples push from out_ready; the single-entry build refills on pop.
  always_comb begin
    pop = (cnt != 2'd0) && out_ready;
`ifdef FETCH_SKID2_EN
    can_push = (cnt < 2'(DEPTH));
`else
    can_push = (cnt == 2'd0) || pop;
`endif
    push   = !redirect && !halt && can_push;
    wr_idx = cnt - 2'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc       <= RESET_PC;
      cnt       <= 2'd0;
      wrapped_q <= 1'b0;
    end else if (redirect) begin
      fpc <= redirect_pc;
      cnt <= 2'd0;
    end else begin
      cnt <= cnt + 2'(push) - 2'(pop);
      if (push) begin
        fpc <= fpc + ADDR_W'(1);
        if (fpc == '1) wrapped_q <= 1'b1;
      end
    end
  end

  // Shift-register FIFO: slot 0 is always the head, so outputs come straight from flops.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    if (g < DEPTH - 1) begin : g_next
      assign shift_src[g] = fifo_q[g+1];
    end else begin : g_last
      assign shift_src[g] = fifo_q[g];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        fifo_q[g] <= '0;
      end else if (!redirect) begin
        if (push && (wr_idx == 2'(g))) begin
          fifo_q[g] <= new_entry;
        end else if (pop) begin
          fifo_q[g] <= shift_src[g];
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner-case sequences
// and randomized traffic compared against a queue-based reference model.
module tb_fetch_unit;

  localparam int         ADDR_W   = 8;
  localparam int         WORD_W   = 32;
  localparam logic [7:0] RESET_PC = 8'h00;
`ifdef FETCH_SKID2_EN
  localparam int DEPTH = 2;
  localparam bit SKID  = 1'b1;
`else
  localparam int DEPTH = 1;
  localparam bit SKID  = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] instr_addr;
  logic [WORD_W-1:0] instr_in;
  logic [ADDR_W-1:0] data_addr;
  logic [WORD_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_instr;
  logic [WORD_W-1:0] out_data;
  logic [ADDR_W-1:0] out_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              wrapped;

  fetch_unit #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .instr_addr(instr_addr), .instr_in(instr_in),
    .data_addr(data_addr), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_data(out_data), .out_pc(out_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .wrapped(wrapped)
  );

  function automatic logic [31:0] instr_of(input logic [7:0] pc);
    return 32'h1000_0000 + {24'h0, pc};
  endfunction

  function automatic logic [31:0] data_of(input logic [7:0] pc);
    return 32'hD000_0000 + {24'h0, pc};
  endfunction

  assign instr_in = instr_of(instr_addr);
  assign data_in  = data_of(data_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  int         checks;
  int         failures;
  logic [7:0] mq [$];
  logic [7:0] m_fpc;
  bit         m_wrapped;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc     = RESET_PC;
    m_wrapped = 1'b0;
  endtask

  // Behavioural view: a queue of fetched PCs bounded by DEPTH; redirect wins.
  task automatic model_edge(input bit rdy, input bit rd, input logic [7:0] rpc, input bit hl);
    int sz;
    bit p;
    bit cp;
    sz = mq.size();
    p  = (sz != 0) && rdy;
    if (rd) begin
      mq.delete();
      m_fpc = rpc;
    end else begin
      cp = SKID ? (sz < DEPTH) : ((sz == 0) || p);
      if (p) void'(mq.pop_front());
      if (!hl && cp) begin
        mq.push_back(m_fpc);
        if (m_fpc == 8'hFF) m_wrapped = 1'b1;
        m_fpc = m_fpc + 8'd1;
      end
    end
  endtask

  task automatic check_output();
    check("out_valid", {31'b0, out_valid}, {31'b0, (mq.size() != 0)});
    check("instr_addr", {24'h0, instr_addr}, {24'h0, m_fpc});
    check("data_addr", {24'h0, data_addr}, {24'h0, m_fpc});
    check("wrapped", {31'b0, wrapped}, {31'b0, m_wrapped});
    if (mq.size() != 0) begin
      check("out_pc", {24'h0, out_pc}, {24'h0, mq[0]});
      check("out_instr", out_instr, instr_of(mq[0]));
      check("out_data", out_data, data_of(mq[0]));
    end
  endtask

  task automatic apply_stimulus(input bit rdy, input bit rd, input logic [7:0] rpc, input bit hl);
    out_ready   = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = hl;
    @(posedge clk);
    model_edge(rdy, rd, rpc, hl);
    @(negedge clk);
    check_output();
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    halt        = 1'b0;
    #1;
    model_reset();
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset out_pc", {24'h0, out_pc}, 32'd0);
    check("reset out_instr", out_instr, 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset instr_addr", {24'h0, instr_addr}, {24'h0, RESET_PC});
    check("reset wrapped", {31'b0, wrapped}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    bit         rdy;
    bit         rd;
    logic [7:0] rpc;
    bit         hl;
    bit         exp_valid;
    logic [7:0] exp_pc;
    logic [7:0] exp_addr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h01};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 8'h02};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 8'h03};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 8'h04};
    vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 8'h05};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 8'h06};
    vecs[6] = '{1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 8'h40};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h40, 8'h41};
    vecs[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 8'h42};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(vecs[i].rdy, vecs[i].rd, vecs[i].rpc, vecs[i].hl);
      check($sformatf("vec%0d valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d addr", i), {24'h0, instr_addr}, {24'h0, vecs[i].exp_addr});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d pc", i), {24'h0, out_pc}, {24'h0, vecs[i].exp_pc});
        check($sformatf("vec%0d instr", i), out_instr, instr_of(vecs[i].exp_pc));
      end
    end

    // Backpressure: stall with PC 2 at the head, then release.
    do_reset();
    repeat (3) apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
    check("bp head", {24'h0, out_pc}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
      check("bp hold pc", {24'h0, out_pc}, 32'd2);
      check("bp fpc", {24'h0, instr_addr}, 32'(2 + DEPTH));
    end
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
      check("bp release valid", {31'b0, out_valid}, 32'd1);
      check("bp release pc", {24'h0, out_pc}, 32'(3 + i));
    end

    // Halt at PC 10: drain, freeze, resume in order; redirect during halt.
    do_reset();
    repeat (11) apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
    check("halt head", {24'h0, out_pc}, 32'd10);
    repeat (4) apply_stimulus(1'b1, 1'b0, 8'h00, 1'b1);
    check("halt drained", {31'b0, out_valid}, 32'd0);
    check("halt frozen", {24'h0, instr_addr}, 32'd11);
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
    check("halt resume pc", {24'h0, out_pc}, 32'd11);
    apply_stimulus(1'b1, 1'b1, 8'h80, 1'b1);
    check("halt redirect addr", {24'h0, instr_addr}, 32'h80);
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
    check("halt redirect pc", {24'h0, out_pc}, 32'h80);

    // Wrap past 8'hFF and stickiness across redirect.
    apply_stimulus(1'b1, 1'b1, 8'hFE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
      check("wrap pc", {24'h0, out_pc}, {24'h0, 8'(8'hFE + i)});
      check("wrap flag", {31'b0, wrapped}, {31'b0, (i >= 1)});
    end
    apply_stimulus(1'b1, 1'b1, 8'h20, 1'b0);
    check("wrap sticky", {31'b0, wrapped}, 32'd1);

    // Async reset between edges with entries buffered.
    repeat (3) apply_stimulus(1'b0, 1'b0, 8'h00, 1'b0);
    check("pre-reset valid", {31'b0, out_valid}, 32'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async out_valid", {31'b0, out_valid}, 32'd0);
    check("async instr_addr", {24'h0, instr_addr}, {24'h0, RESET_PC});
    check("async out_pc", {24'h0, out_pc}, 32'd0);
    check("async out_instr", out_instr, 32'd0);
    check("async wrapped", {31'b0, wrapped}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1'b1, 1'b0, 8'h00, 1'b0);
    check("post-reset pc", {24'h0, out_pc}, {24'h0, RESET_PC});

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                     8'($urandom), $urandom_range(0, 9) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
